// File: rtl/spi_cfg_pkg.sv
// rtl/spi_cfg_pkg.sv - opcodes, FSM states and register-bank address map for spi_cfg_bank
package spi_cfg_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WR,
    ST_RD,
    ST_STAT,
    ST_IGNORE
  } state_t;

  // Bank layout consumed by the SNN core; the 125-byte default ends at debug_config.
  localparam int ADDR_DECAY        = 'h00;
  localparam int ADDR_REFRACTORY   = 'h01;
  localparam int ADDR_THRESHOLD    = 'h02;
  localparam int ADDR_DIV_VALUE    = 'h03;
  localparam int ADDR_WEIGHTS      = 'h04;
  localparam int NUM_WEIGHTS       = 64;
  localparam int ADDR_DELAYS       = ADDR_WEIGHTS + NUM_WEIGHTS;
  localparam int NUM_DELAYS        = 56;
  localparam int ADDR_DEBUG_CONFIG = ADDR_DELAYS + NUM_DELAYS;

endpackage

// File: rtl/spi_cfg_bank_if.sv
// rtl/spi_cfg_bank_if.sv - SPI pin bundle between an external host and spi_cfg_bank
interface spi_cfg_bank_if;

  logic sclk;
  logic ss_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (
    output sclk,
    output ss_n,
    output mosi,
    input  miso,
    input  miso_oe
  );

  modport slave (
    input  sclk,
    input  ss_n,
    input  mosi,
    output miso,
    output miso_oe
  );

endinterface

// File: rtl/spi_bit_engine.sv
// rtl/spi_bit_engine.sv - SPI mode-0 oversampler: synchronisers, edge detect, rx/tx shifters, bit counter
module spi_bit_engine #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sclk,
  input  logic       ss_n,
  input  logic       mosi,
  input  logic       tx_load,
  input  logic [7:0] tx_byte,
  output logic       ss_active,
  output logic       ss_fall,
  output logic       ss_rise,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       tx_bit
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_q;
  logic                   ss_q;
  logic                   sclk_s;
  logic                   ss_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx_sh;
  logic [7:0]             tx_sh;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Select idles high, so the synchroniser resets high to avoid a false falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      ss_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_q    <= sclk_s;
      ss_q      <= ss_s;
    end
  end

  // Clock edges only count while selected, so a deselect in the same cycle wins.
  assign ss_fall    = ss_q & ~ss_s;
  assign ss_rise    = ~ss_q & ss_s;
  assign sclk_rise  = sclk_s & ~sclk_q & ~ss_s;
  assign sclk_fall  = ~sclk_s & sclk_q & ~ss_s;
  assign ss_active  = ~ss_s;
  assign byte_valid = sclk_rise & (bit_cnt == 3'd7);
  assign rx_byte    = {rx_sh, mosi_s};
  assign tx_bit     = tx_sh[7];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      rx_sh   <= '0;
    end else if (ss_s) begin
      bit_cnt <= '0;
      rx_sh   <= '0;
    end else if (sclk_rise) begin
      bit_cnt <= bit_cnt + 3'd1;
      rx_sh   <= {rx_sh[5:0], mosi_s};
    end
  end

  // The falling edge right after a byte boundary must not shift out the freshly loaded MSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_sh <= '0;
    end else if (ss_s) begin
      tx_sh <= '0;
    end else if (tx_load) begin
      tx_sh <= tx_byte;
    end else if (sclk_fall && (bit_cnt != 3'd0)) begin
      tx_sh <= {tx_sh[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/spi_cfg_bank.sv
// rtl/spi_cfg_bank.sv - SPI-framed configuration register bank with burst write/read, status and error flag
module spi_cfg_bank
  import spi_cfg_pkg::*;
#(
  parameter int MEM_BYTES   = 125,
  parameter int ADDR_BYTES  = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  spi_cfg_bank_if.slave           spi,
  output logic [MEM_BYTES*8-1:0]  all_data_out,
  output logic                    wr_strobe,
  output logic [8*ADDR_BYTES-1:0] wr_addr,
  output logic                    txn_done,
  output logic                    cmd_error
);

  localparam int                ADDR_W     = 8 * ADDR_BYTES;
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(MEM_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(MEM_BYTES - 1);
  localparam logic [1:0]        ADDR_FINAL = 2'(ADDR_BYTES - 1);

  state_t            state;
  state_t            state_nxt;
  logic              is_read;
  logic              is_read_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W-1:0] addr_full;
  logic [ADDR_W-1:0] addr_inc;
  logic [1:0]        addr_cnt;
  logic [1:0]        addr_cnt_nxt;
  logic              err_prev;
  logic              err_set;
  logic              wr_en;
  logic [7:0]        bank [MEM_BYTES];
  logic [7:0]        rd_full;
  logic [7:0]        rd_inc;

  logic              ss_active;
  logic              ss_fall;
  logic              ss_rise;
  logic              byte_valid;
  logic [7:0]        rx_byte;
  logic              tx_bit;
  logic              tx_load;
  logic [7:0]        tx_byte;

  spi_bit_engine #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bit_engine (
    .clk        (clk),
    .reset_n    (reset_n),
    .sclk       (spi.sclk),
    .ss_n       (spi.ss_n),
    .mosi       (spi.mosi),
    .tx_load    (tx_load),
    .tx_byte    (tx_byte),
    .ss_active  (ss_active),
    .ss_fall    (ss_fall),
    .ss_rise    (ss_rise),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .tx_bit     (tx_bit)
  );

  // Address bytes arrive MSB first; the running address is the previous bytes plus this one.
  if (ADDR_BYTES == 1) begin : g_addr_one
    assign addr_full = rx_byte;
  end else begin : g_addr_multi
    assign addr_full = {addr[ADDR_W-9:0], rx_byte};
  end

  assign addr_inc = (addr == ADDR_LAST) ? '0 : addr + ADDR_W'(1);

  always_comb begin
    rd_full = '0;
    rd_inc  = '0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      if (addr_full == ADDR_W'(i)) rd_full = bank[i];
      if (addr_inc == ADDR_W'(i))  rd_inc  = bank[i];
    end
  end

  always_comb begin
    state_nxt    = state;
    is_read_nxt  = is_read;
    addr_nxt     = addr;
    addr_cnt_nxt = addr_cnt;
    err_set      = 1'b0;
    wr_en        = 1'b0;
    tx_load      = 1'b0;
    tx_byte      = '0;
    if (ss_rise) begin
      state_nxt = ST_IDLE;
    end else if (ss_fall) begin
      state_nxt    = ST_CMD;
      addr_cnt_nxt = '0;
    end else if (byte_valid) begin
      case (state)
        ST_CMD: begin
          case (rx_byte)
            OP_WRITE: begin
              state_nxt   = ST_ADDR;
              is_read_nxt = 1'b0;
            end
            OP_READ: begin
              state_nxt   = ST_ADDR;
              is_read_nxt = 1'b1;
            end
            OP_STATUS: begin
              state_nxt = ST_STAT;
              tx_load   = 1'b1;
              tx_byte   = {7'b0, err_prev};
            end
            default: begin
              state_nxt = ST_IGNORE;
              err_set   = 1'b1;
            end
          endcase
        end
        ST_ADDR: begin
          addr_nxt     = addr_full;
          addr_cnt_nxt = addr_cnt + 2'd1;
          if (addr_cnt == ADDR_FINAL) begin
            if ({1'b0, addr_full} >= ADDR_LIMIT) begin
              state_nxt = ST_IGNORE;
              err_set   = 1'b1;
            end else if (is_read) begin
              state_nxt = ST_RD;
              tx_load   = 1'b1;
              tx_byte   = rd_full;
            end else begin
              state_nxt = ST_WR;
            end
          end
        end
        ST_WR: begin
          wr_en    = 1'b1;
          addr_nxt = addr_inc;
        end
        ST_RD: begin
          addr_nxt = addr_inc;
          tx_load  = 1'b1;
          tx_byte  = rd_inc;
        end
        ST_STAT: begin
          tx_load = 1'b1;
          tx_byte = {7'b0, err_prev};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      is_read   <= 1'b0;
      addr      <= '0;
      addr_cnt  <= '0;
      err_prev  <= 1'b0;
      cmd_error <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      txn_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      is_read   <= is_read_nxt;
      addr      <= addr_nxt;
      addr_cnt  <= addr_cnt_nxt;
      wr_strobe <= wr_en;
      txn_done  <= ss_rise;
      if (wr_en) wr_addr <= addr;
      // The status opcode reports the error left over from the previous transaction.
      if (ss_fall) begin
        err_prev  <= cmd_error;
        cmd_error <= 1'b0;
      end else if (err_set) begin
        cmd_error <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MEM_BYTES; i++) bank[i] <= '0;
    end else begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        if (wr_en && (addr == ADDR_W'(i))) bank[i] <= rx_byte;
      end
    end
  end

  for (genvar g = 0; g < MEM_BYTES; g++) begin : g_flat
    assign all_data_out[8*g +: 8] = bank[g];
  end

  assign spi.miso    = ss_active && ((state == ST_RD) || (state == ST_STAT)) ? tx_bit : 1'b0;
  assign spi.miso_oe = ss_active;

endmodule

// File: tb/tb_spi_cfg_bank.sv
// tb/tb_spi_cfg_bank.sv - directed bench for spi_cfg_bank driving SPI mode 0 at clk/10
module tb_spi_cfg_bank;

  localparam int MEM_BYTES = 125;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic [MEM_BYTES*8-1:0] all_data_out;
  logic                   wr_strobe;
  logic [7:0]             wr_addr;
  logic                   txn_done;
  logic                   cmd_error;

  spi_cfg_bank_if spi ();

  spi_cfg_bank #(
    .MEM_BYTES   (MEM_BYTES),
    .ADDR_BYTES  (1),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spi          (spi),
    .all_data_out (all_data_out),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .txn_done     (txn_done),
    .cmd_error    (cmd_error)
  );

  always #5 clk = ~clk;

  int         strobe_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] strobe_addr [$];

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt <= strobe_cnt + 1;
      strobe_addr.push_back(wr_addr);
    end
    if (txn_done) done_cnt <= done_cnt + 1;
  end

  int         total = 0;
  int         passed = 0;
  int         failed = 0;
  logic [7:0] model [MEM_BYTES];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bank(input string tag);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MEM_BYTES; i++)
      if (all_data_out[8*i +: 8] !== model[i]) ok = 1'b0;
    check(tag, 32'(ok), 1);
  endtask

  task automatic spi_bits(input logic [7:0] val, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      spi.mosi = val[i];
      #50;
      rx[i] = spi.miso;
      spi.sclk = 1'b1;
      #50;
      spi.sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] val, output logic [7:0] rx);
    spi_bits(val, 8, rx);
  endtask

  task automatic ss_begin();
    spi.ss_n = 1'b0;
    #100;
  endtask

  task automatic ss_end();
    #100;
    spi.ss_n = 1'b1;
    #200;
  endtask

  initial begin
    logic [7:0] r;
    int         s0;
    int         d0;
    int         q0;

    spi.sclk = 1'b0;
    spi.ss_n = 1'b1;
    spi.mosi = 1'b0;
    for (int i = 0; i < MEM_BYTES; i++) model[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_wr_strobe", 32'(wr_strobe), 0);
    check("reset_txn_done", 32'(txn_done), 0);
    check("reset_cmd_error", 32'(cmd_error), 0);
    check("reset_miso", 32'(spi.miso), 0);
    check("reset_miso_oe", 32'(spi.miso_oe), 0);
    check("reset_wr_addr", 32'(wr_addr), 0);
    check_bank("reset_bank");
    reset_n = 1'b1;
    #50;

    // Write burst 02 00 AA BB CC
    s0 = strobe_cnt; d0 = done_cnt; q0 = strobe_addr.size();
    ss_begin();
    check("miso_oe_selected", 32'(spi.miso_oe), 1);
    spi_byte(8'h02, r); spi_byte(8'h00, r);
    spi_byte(8'hAA, r); spi_byte(8'hBB, r); spi_byte(8'hCC, r);
    ss_end();
    model[0] = 8'hAA; model[1] = 8'hBB; model[2] = 8'hCC;
    check_bank("wr_burst_bank");
    check("wr_burst_strobes", strobe_cnt - s0, 3);
    check("wr_burst_addr0", 32'(strobe_addr[q0]), 0);
    check("wr_burst_addr1", 32'(strobe_addr[q0+1]), 1);
    check("wr_burst_addr2", 32'(strobe_addr[q0+2]), 2);
    check("wr_burst_txn_done", done_cnt - d0, 1);
    check("wr_burst_cmd_error", 32'(cmd_error), 0);
    check("miso_oe_deselected", 32'(spi.miso_oe), 0);

    // Read back from address 1
    s0 = strobe_cnt;
    ss_begin();
    spi_byte(8'h03, r);
    check("rd_miso_cmd_phase", 32'(r), 0);
    spi_byte(8'h01, r);
    spi_byte(8'h00, r);
    check("rd_byte0", 32'(r), 'hBB);
    spi_byte(8'h00, r);
    check("rd_byte1", 32'(r), 'hCC);
    ss_end();
    check("rd_no_strobe", strobe_cnt - s0, 0);
    check_bank("rd_bank_unchanged");

    // Write wrap at the top of the bank
    s0 = strobe_cnt; q0 = strobe_addr.size();
    ss_begin();
    spi_byte(8'h02, r); spi_byte(8'h7C, r); spi_byte(8'h11, r); spi_byte(8'h22, r);
    ss_end();
    model[124] = 8'h11; model[0] = 8'h22;
    check_bank("wrap_bank");
    check("wrap_strobes", strobe_cnt - s0, 2);
    check("wrap_addr0", 32'(strobe_addr[q0]), 'h7C);
    check("wrap_addr1", 32'(strobe_addr[q0+1]), 0);

    // Unknown opcode
    s0 = strobe_cnt;
    ss_begin();
    spi_byte(8'h9F, r); spi_byte(8'h33, r);
    ss_end();
    check("badop_cmd_error", 32'(cmd_error), 1);
    check("badop_no_strobe", strobe_cnt - s0, 0);
    check_bank("badop_bank");

    // Status reports the previous error and clears the flag
    ss_begin();
    check("stat_error_cleared", 32'(cmd_error), 0);
    spi_byte(8'h05, r);
    spi_byte(8'h00, r);
    check("stat_byte0", 32'(r), 1);
    spi_byte(8'h00, r);
    check("stat_byte1", 32'(r), 1);
    ss_end();
    check("stat_cmd_error_after", 32'(cmd_error), 0);

    // Out-of-range address
    s0 = strobe_cnt;
    ss_begin();
    spi_byte(8'h02, r); spi_byte(8'h7D, r); spi_byte(8'h44, r);
    ss_end();
    check("badaddr_cmd_error", 32'(cmd_error), 1);
    check("badaddr_no_strobe", strobe_cnt - s0, 0);
    check_bank("badaddr_bank");

    // Abort mid-byte
    s0 = strobe_cnt; d0 = done_cnt;
    ss_begin();
    spi_byte(8'h02, r); spi_byte(8'h10, r);
    spi_bits(8'hFF, 5, r);
    spi.sclk = 1'b0;
    ss_end();
    check("abort_byte10", 32'(all_data_out[8*16 +: 8]), 0);
    check("abort_no_strobe", strobe_cnt - s0, 0);
    check("abort_txn_done", done_cnt - d0, 1);
    check("abort_cmd_error", 32'(cmd_error), 0);
    s0 = strobe_cnt; q0 = strobe_addr.size();
    ss_begin();
    spi_byte(8'h02, r); spi_byte(8'h10, r); spi_byte(8'h5A, r);
    ss_end();
    model[16] = 8'h5A;
    check_bank("post_abort_bank");
    check("post_abort_strobes", strobe_cnt - s0, 1);
    check("post_abort_addr", 32'(strobe_addr[q0]), 'h10);

    // Reset during a write data byte
    ss_begin();
    spi_byte(8'h02, r); spi_byte(8'h05, r);
    spi_bits(8'hF0, 4, r);
    reset_n = 1'b0;
    #30;
    for (int i = 0; i < MEM_BYTES; i++) model[i] = 8'h00;
    check_bank("rst_mid_bank");
    check("rst_mid_wr_strobe", 32'(wr_strobe), 0);
    check("rst_mid_wr_addr", 32'(wr_addr), 0);
    check("rst_mid_cmd_error", 32'(cmd_error), 0);
    check("rst_mid_txn_done", 32'(txn_done), 0);
    check("rst_mid_miso", 32'(spi.miso), 0);
    check("rst_mid_miso_oe", 32'(spi.miso_oe), 0);
    spi.ss_n = 1'b1;
    #100;
    reset_n = 1'b1;
    #100;
    s0 = strobe_cnt; q0 = strobe_addr.size();
    ss_begin();
    spi_byte(8'h02, r); spi_byte(8'h03, r); spi_byte(8'h55, r);
    ss_end();
    model[3] = 8'h55;
    check_bank("post_reset_bank");
    check("post_reset_strobes", strobe_cnt - s0, 1);
    check("post_reset_addr", 32'(strobe_addr[q0]), 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
